// File: rtl/bcrypt_pkg.sv
// Shared types and constants for the Blowfish/bcrypt key-schedule block.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package bcrypt_pkg;

    localparam int P_ENTRIES = 18;
    localparam int S_ENTRIES = 256;
    localparam int NUM_ENC   = 521;
    localparam int S1_BASE   = 18;
    localparam int S2_BASE   = 274;
    localparam int S3_BASE   = 530;
    localparam int S4_BASE   = 786;
    localparam int IDX_W     = 11;

    typedef enum logic [3:0] {
        IDLE,
        KX_RD,
        KX_W0,
        KX_W1,
        KX_WR,
        ENC_GO,
        ENC_WAIT,
        ST_L,
        ST_R,
        DONE
    } state_t;

    // One SRAM control bundle: select, write enable (both active low), address.
    typedef struct packed {
        logic       cs_l;
        logic       we_l;
        logic [7:0] addr;
    } mem_port_t;

endpackage

// File: rtl/store_decode.sv
// Maps an 11-bit linear store index onto the P / S1..S4 write ports.
// Latency: combinational.
// Backpressure: none; an idle strobe leaves every port deselected.
module store_decode
    import bcrypt_pkg::*;
(
    input  logic [IDX_W-1:0] idx,
    input  logic             wr,
    output mem_port_t        p_port,
    output mem_port_t [3:0]  s_port
);

    // Select exactly one memory for the index range it owns; all others stay idle.
    always_comb begin
        p_port = '{cs_l: 1'b1, we_l: 1'b1, addr: 8'd0};
        for (int m = 0; m < 4; m++) begin
            s_port[m] = '{cs_l: 1'b1, we_l: 1'b1, addr: 8'd0};
        end
        if (wr) begin
            if (idx < IDX_W'(S1_BASE)) begin
                p_port = '{cs_l: 1'b0, we_l: 1'b0, addr: idx[7:0]};
            end else if (idx < IDX_W'(S2_BASE)) begin
                s_port[0] = '{cs_l: 1'b0, we_l: 1'b0, addr: 8'(idx - IDX_W'(S1_BASE))};
            end else if (idx < IDX_W'(S3_BASE)) begin
                s_port[1] = '{cs_l: 1'b0, we_l: 1'b0, addr: 8'(idx - IDX_W'(S2_BASE))};
            end else if (idx < IDX_W'(S4_BASE)) begin
                s_port[2] = '{cs_l: 1'b0, we_l: 1'b0, addr: 8'(idx - IDX_W'(S3_BASE))};
            end else if (idx < IDX_W'(S4_BASE + S_ENTRIES)) begin
                s_port[3] = '{cs_l: 1'b0, we_l: 1'b0, addr: 8'(idx - IDX_W'(S4_BASE))};
            end
        end
    end

endmodule

// File: rtl/expand_key.sv
// bcrypt ExpandKey controller: key XOR into P, then 521 chained Feistel encryptions stored over P/S.
// Latency: start to done = 1 + 72 + 521*(F+3) + 1 cycles, F = feistel start-to-done cycles.
// Backpressure: stalls in ENC_WAIT until fe_done; start while busy is ignored.
module expand_key
    import bcrypt_pkg::*;
#(
    parameter int W             = 32,
    parameter int KEY_WORDS_MAX = 18
) (
    input  logic           clk,
    input  logic           reset_l,
    input  logic           start,
    input  logic           salt_en,
    input  logic [4*W-1:0] salt,
    input  logic [4:0]     key_len,
    output logic [4:0]     key_addr,
    output logic           key_cs_l,
    input  logic [W-1:0]   key_out,
    output logic [7:0]     p_addr,
    output logic           p_cs_l,
    output logic           p_we_l,
    output logic [W-1:0]   p_in,
    input  logic [W-1:0]   p_out,
    output logic [7:0]     s1_addr,
    output logic [7:0]     s2_addr,
    output logic [7:0]     s3_addr,
    output logic [7:0]     s4_addr,
    output logic           s1_cs_l,
    output logic           s2_cs_l,
    output logic           s3_cs_l,
    output logic           s4_cs_l,
    output logic           s1_we_l,
    output logic           s2_we_l,
    output logic           s3_we_l,
    output logic           s4_we_l,
    output logic [W-1:0]   s_in,
    output logic           fe_start,
    output logic [W-1:0]   fe_L,
    output logic [W-1:0]   fe_R,
    input  logic           fe_done,
    input  logic [W-1:0]   fe_resultL,
    input  logic [W-1:0]   fe_resultR,
    output logic           fe_active,
    output logic           busy,
    output logic           done
);

    state_t           state, state_nxt;
    logic [4:0]       kx_idx;
    logic [4:0]       key_idx;
    logic [4:0]       key_len_q;
    logic [9:0]       enc_idx;
    logic             salt_en_q;
    logic [W-1:0]     l_q, r_q;
    logic [4:0]       key_len_eff;
    logic [W-1:0]     salt_a, salt_b;
    logic [IDX_W-1:0] st_idx;
    logic             st_wr;
    logic [W-1:0]     st_dat;
    mem_port_t        p_port;
    mem_port_t [3:0]  s_port;

    assign key_len_eff = (key_len == 5'd0 || key_len > 5'(KEY_WORDS_MAX)) ?
                         5'(KEY_WORDS_MAX) : key_len;

    // Even encryptions use the upper salt half, odd ones the lower half.
    assign salt_a = !salt_en_q ? '0 : (enc_idx[0] ? salt[2*W-1 -: W] : salt[4*W-1 -: W]);
    assign salt_b = !salt_en_q ? '0 : (enc_idx[0] ? salt[W-1:0]      : salt[3*W-1 -: W]);

    assign st_wr  = (state == ST_L) || (state == ST_R);
    assign st_idx = {enc_idx, (state == ST_R)};
    assign st_dat = (state == ST_R) ? r_q : l_q;

    store_decode u_store_decode (
        .idx    (st_idx),
        .wr     (st_wr),
        .p_port (p_port),
        .s_port (s_port)
    );

    // State register.
    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) state <= IDLE;
        else          state <= state_nxt;
    end

    // Next-state sequencing through key XOR, encrypt and store phases.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (start) state_nxt = KX_RD;
            KX_RD:    state_nxt = KX_W0;
            KX_W0:    state_nxt = KX_W1;
            KX_W1:    state_nxt = KX_WR;
            KX_WR:    state_nxt = (kx_idx == 5'(P_ENTRIES - 1)) ? ENC_GO : KX_RD;
            ENC_GO:   state_nxt = ENC_WAIT;
            ENC_WAIT: if (fe_done) state_nxt = ST_L;
            ST_L:     state_nxt = ST_R;
            ST_R:     state_nxt = (enc_idx == 10'(NUM_ENC - 1)) ? DONE : ENC_GO;
            DONE:     state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // Loop counters, captured parameters, chained block and feistel handshake registers.
    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            kx_idx    <= '0;
            key_idx   <= '0;
            key_len_q <= '0;
            enc_idx   <= '0;
            salt_en_q <= 1'b0;
            l_q       <= '0;
            r_q       <= '0;
            fe_L      <= '0;
            fe_R      <= '0;
            fe_start  <= 1'b0;
        end else begin
            fe_start <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    kx_idx    <= '0;
                    key_idx   <= '0;
                    enc_idx   <= '0;
                    key_len_q <= key_len_eff;
                    salt_en_q <= salt_en;
                end
                KX_WR: begin
                    key_idx <= (key_idx + 5'd1 == key_len_q) ? 5'd0 : key_idx + 5'd1;
                    if (kx_idx == 5'(P_ENTRIES - 1)) begin
                        l_q     <= '0;
                        r_q     <= '0;
                        enc_idx <= '0;
                    end else begin
                        kx_idx <= kx_idx + 5'd1;
                    end
                end
                ENC_GO: begin
                    fe_L     <= l_q ^ salt_a;
                    fe_R     <= r_q ^ salt_b;
                    fe_start <= 1'b1;
                end
                ENC_WAIT: if (fe_done) begin
                    l_q <= fe_resultL;
                    r_q <= fe_resultR;
                end
                ST_R: if (enc_idx != 10'(NUM_ENC - 1)) enc_idx <= enc_idx + 10'd1;
                default: ;
            endcase
        end
    end

    // SRAM port drive: key/P reads and P write-back during key XOR, decoded stores afterwards.
    always_comb begin
        key_addr = '0;
        key_cs_l = 1'b1;
        p_addr   = '0;
        p_cs_l   = 1'b1;
        p_we_l   = 1'b1;
        p_in     = '0;
        s_in     = '0;
        case (state)
            KX_RD: begin
                key_cs_l = 1'b0;
                p_cs_l   = 1'b0;
                key_addr = key_idx;
                p_addr   = {3'b000, kx_idx};
            end
            KX_W0, KX_W1: begin
                key_addr = key_idx;
                p_addr   = {3'b000, kx_idx};
            end
            KX_WR: begin
                key_addr = key_idx;
                p_addr   = {3'b000, kx_idx};
                p_cs_l   = 1'b0;
                p_we_l   = 1'b0;
                p_in     = p_out ^ key_out;
            end
            ST_L, ST_R: begin
                p_addr = p_port.addr;
                p_cs_l = p_port.cs_l;
                p_we_l = p_port.we_l;
                p_in   = st_dat;
                s_in   = st_dat;
            end
            default: ;
        endcase
    end

    assign s1_addr = s_port[0].addr;
    assign s2_addr = s_port[1].addr;
    assign s3_addr = s_port[2].addr;
    assign s4_addr = s_port[3].addr;
    assign s1_cs_l = s_port[0].cs_l;
    assign s2_cs_l = s_port[1].cs_l;
    assign s3_cs_l = s_port[2].cs_l;
    assign s4_cs_l = s_port[3].cs_l;
    assign s1_we_l = s_port[0].we_l;
    assign s2_we_l = s_port[1].we_l;
    assign s3_we_l = s_port[2].we_l;
    assign s4_we_l = s_port[3].we_l;

    assign fe_active = (state == ENC_WAIT);
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);

endmodule

// File: doc/expand_key.md
# expand_key

Blowfish/bcrypt key-schedule controller directly downstream of the `feistel` round engine. It XORs the P-array with the cyclically repeated key, then chains 521 Feistel encryptions. Each encryption's (L,R) result is written back, in order, over P[0..17] and S1..S4[0..255]. An optional 128-bit salt is XORed into the chained block before each encryption: EksBlowfish `ExpandKey(salt,key)` when `salt_en`=1, plain `ExpandKey(key)` when 0.

## Interface
Parameters:
- `W`, 32, data word width
- `KEY_WORDS_MAX`, 18, key-memory depth in words

Ports:
- `clk`  in  1  clock; all state updates on rising edge
- `reset_l`  in  1  asynchronous, active-low reset
- `start`  in  1  begin expansion; sampled only in IDLE
- `salt_en`  in  1  1 = XOR salt before each encryption; sampled at `start`
- `salt`  in  128  salt; held stable while `busy`
- `key_len`  in  5  key length in words; 0 or >18 treated as 18; sampled at `start`
- `key_addr`  out  5  key-memory read address
- `key_cs_l`  out  1  key-memory chip select, active low
- `key_out`  in  32  key-memory read data, valid 2 cycles after select
- `p_addr`  out  8  P-array address
- `p_cs_l`, `p_we_l`  out  1 each  P-array select / write enable, active low
- `p_in`  out  32  P-array write data
- `p_out`  in  32  P-array read data, 2-cycle latency
- `s1_addr`..`s4_addr`  out  8 each  S-box addresses
- `s1_cs_l`..`s4_cs_l`, `s1_we_l`..`s4_we_l`  out  1 each  S-box select / write enable
- `s_in`  out  32  S-box write data, shared by S1..S4
- `fe_start`  out  1  one-cycle start pulse to `feistel`
- `fe_L`, `fe_R`  out  32 each  block presented to `feistel`, stable from `fe_start` until `fe_done`
- `fe_done`  in  1  `feistel` done pulse
- `fe_resultL`, `fe_resultR`  in  32 each  `feistel` results, valid in the `fe_done` cycle
- `fe_active`  out  1  1 while `feistel` owns the SRAM read ports; top level muxes SRAM address/select on it
- `busy`  out  1  high from the cycle after an accepted `start` until `done`
- `done`  out  1  one-cycle completion pulse

## Operation
- Reset: state IDLE. All `*_cs_l`/`*_we_l` = 1. `fe_start`, `fe_active`, `busy`, `done` = 0. Addresses, data and L/R registers = 0.
- States: IDLE, KX_RD, KX_W0, KX_W1, KX_WR, ENC_GO, ENC_WAIT, ST_L, ST_R, DONE.
- Key-XOR loop, i = 0..17, k = key index:
  - IDLE→KX_RD on `start`; i = 0, k = 0.
  - KX_RD: assert `p_cs_l`, `key_cs_l`; `p_addr`=i, `key_addr`=k.
  - KX_W0, KX_W1: wait cycles.
  - KX_WR: write P[i] ← `p_out` ^ `key_out`. Increment i; k wraps to 0 when k+1 = effective key_len.
  - i=17 → ENC_GO, with L=R=0 and n=0; otherwise → KX_RD.
- Encryption loop, n = 0..520:
  - ENC_GO: `fe_L` = L ^ (`salt_en` ? salt word A : 0), `fe_R` = R ^ (`salt_en` ? salt word B : 0), latched. Words A/B are `salt[127:96]`/`salt[95:64]` for even n, `salt[63:32]`/`salt[31:0]` for odd n. Pulse `fe_start`; raise `fe_active`.
  - ENC_WAIT: hold until `fe_done`; then latch L=`fe_resultL`, R=`fe_resultR`, drop `fe_active`.
  - ST_L: write L to linear index 2n. ST_R: write R to index 2n+1.
  - n=520 after ST_R → DONE; otherwise n++ → ENC_GO.
- Linear index map (11-bit): 0–17 → P[idx]; 18–273 → S1[idx−18]; 274–529 → S2; 530–785 → S3; 786–1041 → S4. Exactly one memory selected per write cycle.
- DONE: `done`=1 for one cycle → IDLE.
- `start` while `busy` is ignored. `fe_done` outside ENC_WAIT is ignored.
- Key index arithmetic: mod effective key_len. Counters do not wrap beyond their terminal values.

## Timing
- Key-XOR phase: 18 × 4 = 72 cycles.
- Per encryption: 1 (ENC_GO) + F + 2 cycles, where F = cycles from `fe_start` to `fe_done` inclusive.
- Total from `start` to `done`: 1 + 72 + 521·(F+3) + 1 cycles.
- A P write in KX_WR is visible to the next KX_RD to the same address. Memories are write-before-read.
- Reset asserted mid-operation: immediate return to IDLE with reset outputs. Memory contents are undefined; software reruns the expansion.

## Structure
- `bcrypt_pkg`: state enum; constants `P_ENTRIES`=18, `S_ENTRIES`=256, `NUM_ENC`=521, `S1_BASE`=18, `S2_BASE`=274, `S3_BASE`=530, `S4_BASE`=786.
- Sub-module `store_decode`: combinational map from linear index + write strobe to per-memory `cs_l`/`we_l` and 8-bit address.

## Test plan
- key_len=1, key word 0xDEADBEEF, P preloaded with π digits: after KX phase, P[i] = π_i ^ 0xDEADBEEF for all 18 entries.
- key_len=3, words {1,2,3}: P[0..5] XORed with 1,2,3,1,2,3. key_len=0 behaves as 18.
- Stub `feistel` returning (L+1, R+2) after F=5, `salt_en`=0: P[0]=1, P[1]=2, S4[255] = final R. Total cycles = 1+72+521·8+1.
- `salt_en`=1, salt=0x0123…EF: the first `fe_L` equals `salt[127:96]` and the second `fe_L` equals resultL ^ `salt[63:32]`. Full run matches a software EksBlowfish golden model.
- `start` pulsed during `busy` → ignored. `fe_done` glitch during ST_L → no state change.
- `reset_l` low during ENC_WAIT at n=100 → outputs return to reset values within the same cycle. A new `start` completes correctly.
